// File: rtl/base_arb_pkg.sv
// rtl/base_arb_pkg.sv - shared arbitration helpers for the packet arbiter
package base_arb_pkg;

    localparam int MAX_WAYS = 16;

    function automatic int calc_sw(input int ways);
        return (ways <= 2) ? 1 : $clog2(ways);
    endfunction

    // Rotating scan from ptr; slots at or above ways are never picked.
    function automatic logic [MAX_WAYS-1:0] rr_pick(input logic [MAX_WAYS-1:0] req,
                                                    input logic [3:0]          ptr,
                                                    input int                  ways);
        logic [MAX_WAYS-1:0] pick;
        logic                found;
        int                  idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= ways) idx = idx - ways;
            if (i < ways && !found && req[idx[3:0]]) begin
                pick[idx[3:0]] = 1'b1;
                found          = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] enc_idx(input logic [MAX_WAYS-1:0] onehot);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            if (onehot[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/base_arb_skid.sv
// rtl/base_arb_skid.sv - two-entry registered skid stage (output register plus skid register)
module base_arb_skid #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_v,
    input  logic [width-1:0] i_d,
    output logic             i_r,
    output logic             o_v,
    output logic [width-1:0] o_d,
    input  logic             o_r
);

    logic             out_v_q, out_v_d;
    logic             sk_v_q, sk_v_d;
    logic [width-1:0] out_d_q, out_d_d;
    logic [width-1:0] sk_d_q, sk_d_d;

    // Ready depends only on registered state so it never combinationally follows o_r.
    assign i_r = ~sk_v_q & ~reset;
    assign o_v = out_v_q;
    assign o_d = out_d_q;

    always_comb begin
        out_v_d = out_v_q;
        out_d_d = out_d_q;
        sk_v_d  = sk_v_q;
        sk_d_d  = sk_d_q;
        if (sk_v_q) begin
            if (out_v_q && o_r) begin
                out_d_d = sk_d_q;
                sk_v_d  = 1'b0;
            end
        end else if (i_v) begin
            if (!out_v_q || o_r) begin
                out_v_d = 1'b1;
                out_d_d = i_d;
            end else begin
                sk_v_d = 1'b1;
                sk_d_d = i_d;
            end
        end else if (o_r) begin
            out_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_v_q <= 1'b0;
            out_d_q <= '0;
            sk_v_q  <= 1'b0;
            sk_d_q  <= '0;
        end else begin
            out_v_q <= out_v_d;
            out_d_q <= out_d_d;
            sk_v_q  <= sk_v_d;
            sk_d_q  <= sk_d_d;
        end
    end

endmodule

// File: rtl/base_rr_pkt_arb.sv
// rtl/base_rr_pkt_arb.sv - round-robin packet-locked arbiter feeding a registered skid output
module base_rr_pkt_arb
    import base_arb_pkg::*;
#(
    parameter int  ways  = 4,
    parameter int  width = 64,
    localparam int sw    = calc_sw(ways)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:ways-1]       i_v,
    input  logic [0:ways*width-1] i_d,
    input  logic [0:ways-1]       i_e,
    output logic [0:ways-1]       i_r,
    output logic                  o_v,
    output logic [0:width-1]      o_d,
    output logic                  o_e,
    output logic [0:sw-1]         o_s,
    input  logic                  o_r
);

    localparam int PW = width + 1 + sw;

    logic                lock_q, lock_d;
    logic [3:0]          owner_q, owner_d;
    logic [3:0]          ptr_q, ptr_d;
    logic [MAX_WAYS-1:0] req, win_oh;
    logic [3:0]          win_idx;
    logic                win_v, win_e, skid_rdy, acc;
    logic [width-1:0]    win_d;
    logic [PW-1:0]       pay_in, pay_out;
    logic                pay_v;

    always_comb begin
        req = '0;
        for (int k = 0; k < ways; k++) req[k] = i_v[k];
        // A locked owner keeps the grant even while its valid is low.
        win_oh  = lock_q ? (MAX_WAYS'(1) << owner_q) : rr_pick(req, ptr_q, ways);
        win_idx = enc_idx(win_oh);
        win_v   = 1'b0;
        win_e   = 1'b0;
        win_d   = '0;
        i_r     = '0;
        for (int k = 0; k < ways; k++) begin
            if (win_oh[k]) begin
                win_v = i_v[k];
                win_e = i_e[k];
                win_d = i_d[k*width +: width];
            end
            i_r[k] = win_oh[k] & skid_rdy;
        end
        acc    = win_v & skid_rdy;
        pay_in = {win_d, win_e, win_idx[sw-1:0]};
    end

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (acc) begin
            if (win_e) begin
                lock_d = 1'b0;
                ptr_d  = (win_idx == 4'(ways - 1)) ? 4'd0 : win_idx + 4'd1;
            end else begin
                lock_d  = 1'b1;
                owner_d = win_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    base_arb_skid #(.width(PW)) u_skid (
        .clk   (clk),
        .reset (reset),
        .i_v   (win_v),
        .i_d   (pay_in),
        .i_r   (skid_rdy),
        .o_v   (pay_v),
        .o_d   (pay_out),
        .o_r   (o_r)
    );

    assign o_v = pay_v;
    assign o_d = pay_out[PW-1 -: width];
    assign o_e = pay_out[sw];
    assign o_s = pay_out[sw-1:0];

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(i_r));

endmodule

// File: tb/tb_base_rr_pkt_arb.sv
// tb/tb_base_rr_pkt_arb.sv - self-checking bench for base_rr_pkt_arb (ways=4 directed, ways=3 random)
module tb_base_rr_pkt_arb;

    localparam int W = 16;

    typedef struct packed {
        logic [1:0]   s;
        logic [W-1:0] d;
        logic         e;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [0:3]     v4 = '0, e4 = '0, ir4;
    logic [0:4*W-1] d4 = '0;
    logic           ov4, oe4, or4 = 1'b1;
    logic [0:W-1]   od4;
    logic [0:1]     os4;

    logic [0:2]     v3 = '0, e3 = '0, ir3;
    logic [0:3*W-1] d3 = '0;
    logic           ov3, oe3, or3 = 1'b1;
    logic [0:W-1]   od3;
    logic [0:1]     os3;

    int checks = 0;
    int failures = 0;
    beat_t q4[$];
    beat_t q3[$];

    base_rr_pkt_arb #(.ways(4), .width(W)) dut4 (
        .clk(clk), .reset(rst), .i_v(v4), .i_d(d4), .i_e(e4), .i_r(ir4),
        .o_v(ov4), .o_d(od4), .o_e(oe4), .o_s(os4), .o_r(or4)
    );

    base_rr_pkt_arb #(.ways(3), .width(W)) dut3 (
        .clk(clk), .reset(rst), .i_v(v3), .i_d(d3), .i_e(e3), .i_r(ir3),
        .o_v(ov3), .o_d(od3), .o_e(oe3), .o_s(os3), .o_r(or3)
    );

    function automatic logic [0:3] m4(input logic [3:0] m);
        logic [0:3] r;
        for (int k = 0; k < 4; k++) r[k] = m[k];
        return r;
    endfunction

    // Scoreboard for the ways=4 instance: push on input accept, pop on output transfer.
    always @(negedge clk) begin
        beat_t exp;
        if (rst) q4.delete();
        else begin
            if (ov4 && or4) begin
                checks++;
                if (q4.size() == 0) begin
                    failures++;
                    $display("FAIL sb4_empty got=%h", {os4, od4, oe4});
                end else begin
                    exp = q4.pop_front();
                    if ({os4, od4, oe4} !== exp) begin
                        failures++;
                        $display("FAIL sb4_beat got=%h exp=%h", {os4, od4, oe4}, exp);
                    end
                end
            end
            for (int k = 0; k < 4; k++)
                if (v4[k] && ir4[k]) q4.push_back('{s: 2'(k), d: d4[k*W +: W], e: e4[k]});
        end
    end

    // Scoreboard for the ways=3 instance, plus packet contiguity on the output.
    logic       in_pkt3 = 1'b0;
    logic [1:0] pkt_src3 = '0;
    always @(negedge clk) begin
        beat_t exp;
        if (rst) begin
            q3.delete();
            in_pkt3 = 1'b0;
        end else begin
            if (ov3 && or3) begin
                checks++;
                if (q3.size() == 0) begin
                    failures++;
                    $display("FAIL sb3_empty got=%h", {os3, od3, oe3});
                end else begin
                    exp = q3.pop_front();
                    if ({os3, od3, oe3} !== exp) begin
                        failures++;
                        $display("FAIL sb3_beat got=%h exp=%h", {os3, od3, oe3}, exp);
                    end
                end
                if (in_pkt3) begin
                    checks++;
                    if (os3 !== pkt_src3) begin
                        failures++;
                        $display("FAIL sb3_contig got=%0d exp=%0d", os3, pkt_src3);
                    end
                end
                in_pkt3  = ~oe3;
                pkt_src3 = os3;
            end
            for (int k = 0; k < 3; k++)
                if (v3[k] && ir3[k]) q3.push_back('{s: 2'(k), d: d3[k*W +: W], e: e3[k]});
        end
    end

    task automatic idle(input int n);
        v4 = '0; e4 = '0; or4 = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v4 = '1; e4 = '1; v3 = '1;
        #12;
        checks += 5;
        if (ir4 !== 4'b0) begin failures++; $display("FAIL rst_ir got=%b exp=0000", ir4); end
        if (ov4 !== 1'b0) begin failures++; $display("FAIL rst_ov got=%b exp=0", ov4); end
        if (od4 !== 16'h0) begin failures++; $display("FAIL rst_od got=%h exp=0", od4); end
        if (oe4 !== 1'b0) begin failures++; $display("FAIL rst_oe got=%b exp=0", oe4); end
        if (os4 !== 2'd0) begin failures++; $display("FAIL rst_os got=%0d exp=0", os4); end
        v4 = '0; e4 = '0; v3 = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rr_all_valid();
        for (int c = 0; c < 9; c++) begin
            v4 = (c < 8) ? 4'b1111 : 4'b0000;
            e4 = 4'b1111;
            for (int k = 0; k < 4; k++) d4[k*W +: W] = {4'(k), 12'(c)};
            @(negedge clk);
            if (c < 8) begin
                checks++;
                if (ir4 !== m4(4'(1 << (c % 4)))) begin
                    failures++; $display("FAIL rr_ir c=%0d got=%b exp=%b", c, ir4, m4(4'(1 << (c % 4))));
                end
            end
            checks++;
            if (ov4 !== (c >= 1)) begin failures++; $display("FAIL rr_ov c=%0d got=%b", c, ov4); end
            if (c >= 1) begin
                checks++;
                if (os4 !== 2'((c - 1) % 4)) begin
                    failures++; $display("FAIL rr_os c=%0d got=%0d exp=%0d", c, os4, (c - 1) % 4);
                end
            end
            @(posedge clk);
            #1;
        end
        idle(2);
    endtask

    task automatic test_packet_lock();
        int cnt[4];
        int got[$];
        int exp_s[5];
        exp_s = '{2, 2, 2, 3, 0};
        // Single beat from 1 moves the pointer to 2.
        v4 = m4(4'b0010); e4 = m4(4'b0010); d4[1*W +: W] = 16'h1111;
        @(negedge clk);
        checks++;
        if (ir4 !== m4(4'b0010)) begin failures++; $display("FAIL pkt_setup got=%b", ir4); end
        @(posedge clk);
        #1;
        idle(1);
        cnt = '{1, 0, 3, 1};
        for (int c = 0; c < 15; c++) begin
            for (int k = 0; k < 4; k++) begin
                v4[k] = (cnt[k] > 0);
                e4[k] = (cnt[k] == 1);
                d4[k*W +: W] = {4'(k), 12'(cnt[k])};
            end
            @(negedge clk);
            if (ov4 && or4) got.push_back(int'(os4));
            for (int k = 0; k < 4; k++) if (v4[k] && ir4[k]) cnt[k]--;
            @(posedge clk);
            #1;
        end
        checks++;
        if (got.size() != 5) begin failures++; $display("FAIL pkt_count got=%0d exp=5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            checks++;
            if (got[i] != exp_s[i]) begin
                failures++; $display("FAIL pkt_order i=%0d got=%0d exp=%0d", i, got[i], exp_s[i]);
            end
        end
        idle(1);
    endtask

    task automatic test_mid_packet_gap();
        logic [3:0] vt[7], et[7], irt[7];
        logic       ovt[7];
        int         ost[7];
        vt  = '{4'b0011, 4'b0001, 4'b0001, 4'b0011, 4'b0001, 4'b0000, 4'b0000};
        et  = '{4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0001, 4'b0000, 4'b0000};
        irt = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0000, 4'b0000};
        ovt = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        ost = '{0, 1, 0, 0, 1, 0, 0};
        for (int c = 0; c < 7; c++) begin
            v4 = m4(vt[c]); e4 = m4(et[c]);
            for (int k = 0; k < 4; k++) d4[k*W +: W] = {4'(k), 12'(16'h300 + c)};
            @(negedge clk);
            checks += 2;
            if (ir4 !== m4(irt[c])) begin failures++; $display("FAIL gap_ir c=%0d got=%b exp=%b", c, ir4, m4(irt[c])); end
            if (ov4 !== ovt[c]) begin failures++; $display("FAIL gap_ov c=%0d got=%b exp=%b", c, ov4, ovt[c]); end
            if (ovt[c]) begin
                checks++;
                if (os4 !== 2'(ost[c])) begin failures++; $display("FAIL gap_os c=%0d got=%0d exp=%0d", c, os4, ost[c]); end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        int n_acc = 0;
        or4 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c == 5) begin or4 = 1'b1; v4 = '0; end
            else if (c < 5) begin v4 = m4(4'b0001); e4 = m4(4'b0001); end
            d4[0 +: W] = 16'h4000 + 16'(c);
            @(negedge clk);
            for (int k = 0; k < 4; k++) if (v4[k] && ir4[k]) n_acc++;
            if (c < 5) begin
                checks++;
                if (ir4 !== ((c < 2) ? m4(4'b0001) : 4'b0000)) begin
                    failures++; $display("FAIL bp_ir c=%0d got=%b", c, ir4);
                end
            end
            if (c >= 1 && c <= 5) begin
                checks += 2;
                if (ov4 !== 1'b1) begin failures++; $display("FAIL bp_ov c=%0d got=%b exp=1", c, ov4); end
                if (od4 !== 16'h4000) begin failures++; $display("FAIL bp_hold c=%0d got=%h exp=4000", c, od4); end
            end
            if (c == 6) begin
                checks += 2;
                if (ov4 !== 1'b1) begin failures++; $display("FAIL bp_drain_ov got=%b exp=1", ov4); end
                if (od4 !== 16'h4001) begin failures++; $display("FAIL bp_drain_od got=%h exp=4001", od4); end
            end
            if (c == 7) begin
                checks++;
                if (ov4 !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", ov4); end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (n_acc != 2) begin failures++; $display("FAIL bp_accepts got=%0d exp=2", n_acc); end
    endtask

    task automatic test_reset_mid_packet();
        or4 = 1'b0;
        v4 = m4(4'b0100); e4 = '0;
        for (int c = 0; c < 3; c++) begin
            d4[2*W +: W] = 16'h5000 + 16'(c);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks += 2;
        if (ir4 !== 4'b0000) begin failures++; $display("FAIL rmp_full_ir got=%b exp=0000", ir4); end
        if (ov4 !== 1'b1) begin failures++; $display("FAIL rmp_full_ov got=%b exp=1", ov4); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks += 2;
        if (ov4 !== 1'b0) begin failures++; $display("FAIL rmp_async_ov got=%b exp=0", ov4); end
        if (ir4 !== 4'b0000) begin failures++; $display("FAIL rmp_async_ir got=%b exp=0000", ir4); end
        v4 = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        or4 = 1'b1;
        v4 = m4(4'b1001); e4 = m4(4'b1001);
        d4[0 +: W] = 16'h6000; d4[3*W +: W] = 16'h6003;
        @(negedge clk);
        checks++;
        if (ir4 !== m4(4'b0001)) begin failures++; $display("FAIL rmp_first got=%b exp=%b", ir4, m4(4'b0001)); end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (ir4 !== m4(4'b1000)) begin failures++; $display("FAIL rmp_second got=%b exp=%b", ir4, m4(4'b1000)); end
        @(posedge clk);
        #1;
        idle(3);
        checks++;
        if (q4.size() != 0) begin failures++; $display("FAIL sb4_leftover got=%0d exp=0", q4.size()); end
    endtask

    task automatic test_random_ways3();
        int         mptr, mown, occ, w;
        logic       mlock, acc, outd;
        logic [0:2] exp_ir;
        mptr = 0; mown = 0; occ = 0; mlock = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < 3; k++) begin
                v3[k] = ($urandom_range(0, 9) < 6);
                e3[k] = 1'($urandom_range(0, 1));
                d3[k*W +: W] = 16'($urandom);
            end
            or3 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            w = -1;
            if (mlock) w = mown;
            else for (int i = 0; i < 3; i++) if (w < 0 && v3[(mptr + i) % 3]) w = (mptr + i) % 3;
            exp_ir = '0;
            if (w >= 0 && occ < 2) exp_ir[w] = 1'b1;
            checks += 2;
            if (ir3 !== exp_ir) begin failures++; $display("FAIL rnd_ir c=%0d got=%b exp=%b", c, ir3, exp_ir); end
            if (ov3 !== (occ > 0)) begin failures++; $display("FAIL rnd_ov c=%0d got=%b exp=%b", c, ov3, occ > 0); end
            acc  = (w >= 0) && v3[w] && (occ < 2);
            outd = (occ > 0) && or3;
            if (acc) begin
                if (e3[w]) begin mlock = 1'b0; mptr = (w + 1) % 3; end
                else begin mlock = 1'b1; mown = w; end
            end
            occ = occ + int'(acc) - int'(outd);
            @(posedge clk);
            #1;
        end
        v3 = '0; or3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q3.size() != 0) begin failures++; $display("FAIL sb3_leftover got=%0d exp=0", q3.size()); end
    endtask

    initial begin
        test_reset();
        test_rr_all_valid();
        test_packet_lock();
        test_mid_packet_gap();
        test_backpressure();
        test_reset_mid_packet();
        test_random_ways3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
